fpu_serial_io: RTL and testbench
================================

# fpu_serial_io

Parametrised serial front end for the half-precision adder/multiplier datapath. It collects two DATA_W-bit operands over a narrow input bus, one IN_W-bit beat per handshake, LSB first. It presents the operands to the external combinational `add`/`mul` units, captures the selected result and its valid flag, and returns the result over an OUT_W-bit output bus with ready/valid backpressure. It replaces fixed-width, counter-driven nibble I/O with a handshaked, width-generic version that can be instantiated at chip level for any DATA_W/IN_W/OUT_W split.

## Interface
- DATA_W, 16, operand and result width.
- IN_W, 4, input beat width; DATA_W % IN_W == 0 is required.
- OUT_W, 8, output beat width; DATA_W % OUT_W == 0 is required.
- Derived: N_IN = DATA_W/IN_W and N_OUT = DATA_W/OUT_W. Both must be ≥ 1.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat offered.
- in_ready  out  1  input beat can be accepted.
- in_a  in  IN_W  operand A slice.
- in_b  in  IN_W  operand B slice.
- op_sel  in  1  1 = add, 0 = multiply; sampled on the first beat of a transaction.
- opa  out  DATA_W  operand A to the units.
- opb  out  DATA_W  operand B to the units.
- add_res  in  DATA_W  adder result.
- add_vld  in  1  adder result-valid flag.
- mul_res  in  DATA_W  multiplier result.
- mul_vld  in  1  multiplier result-valid flag.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  OUT_W  result slice.
- out_last  out  1  marks the final result slice.
- out_flag  out  1  captured unit valid flag; held for the whole response.
- busy  out  1  high whenever state ≠ LOAD or in_cnt ≠ 0.

## Operation
- The FSM has three states: LOAD, CALC and SEND. Reset places it in LOAD.
- Reset values:
  - in_cnt = 0, out_cnt = 0.
  - opa and opb = 0; the result register = 0.
  - out_valid = 0, out_last = 0, out_flag = 0.
  - in_ready = 1 while in LOAD.
  - Any beat offered while reset_n is low is discarded.
- LOAD:
  - in_ready = 1.
  - Each in_valid&&in_ready edge writes in_a into opa bits [in_cnt*IN_W +: IN_W] and in_b into opb the same way, then increments in_cnt.
  - On the beat with in_cnt == 0, op_sel is also latched into sel_q.
  - On the beat with in_cnt == N_IN-1, in_cnt wraps to 0 and the FSM moves to CALC.
  - Operand bits not yet overwritten keep the previous transaction's values. They are fully replaced by the end of the load.
- CALC:
  - Lasts exactly one cycle, with in_ready = 0.
  - At the end of the cycle: result ← sel_q ? add_res : mul_res, and out_flag ← sel_q ? add_vld : mul_vld.
  - out_cnt ← 0 and the FSM moves to SEND.
- SEND:
  - out_valid = 1 and out_data = result[out_cnt*OUT_W +: OUT_W].
  - out_last = (out_cnt == N_OUT-1).
  - On out_valid&&out_ready, out_cnt increments.
  - On the last beat, the FSM moves to LOAD and out_valid and out_last drop.
  - While out_ready is low, out_data and out_last hold stable.
- opa and opb stay stable from the end of LOAD until the next transaction's first beat. This keeps the combinational units' inputs quiet during CALC and SEND.
- out_flag is held from CALC until the next CALC. It is meaningful only while out_valid = 1.
- in_ready = 0 in CALC and SEND; there is no input/output overlap. Upstream stalls (in_valid low) freeze in_cnt indefinitely.
- If reset_n is asserted mid-transaction (any state), everything returns to reset values immediately. A partial load is lost and there is no output beat.

## Timing
- Let E be the edge that accepts the last input beat.
- At E+1, the result is captured and out_valid rises combinationally from SEND.
- The first output handshake can occur at E+2.
- A full transaction with no stalls takes N_IN + 1 + N_OUT cycles. For the default parameters this is 4 + 1 + 2 = 7.
- in_ready rises in the cycle after the last output handshake. A new first beat can be accepted on the next edge.
- Outputs out_valid, out_last, out_data, in_ready and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Add, default parameters:
  - Stimulus: A = 0x3C00, B = 0x4000, op_sel = 1. Feed nibbles LSB first: A 0,0,C,3; B 0,0,0,4. Keep out_ready high.
  - Response: out_data 0x00 then 0x42, out_last on the second beat, out_flag = add_vld, out_valid first high 1 cycle after the 4th input beat.
- Multiply, same operands, op_sel = 0 -> out_data 0x00 then 0x40. Toggling op_sel after the first beat has no effect.
- Backpressure: out_ready low for 5 cycles in SEND -> out_data stays 0x00 and out_valid stays high, with no beat lost; in_ready = 0 throughout.
- Input stalls: in_valid deasserted between every beat -> the same result as the unstalled run, and in_cnt never skips.
- Reset mid-load: reset_n low after 2 beats, then a fresh full transaction -> the correct result with no stale nibbles. out_valid stays 0 during reset.
- Parameter sweep: (DATA_W, IN_W, OUT_W) = (32,8,16) with stub units echoing opa+opb -> correct slice order, out_last on beat 2, total 7 cycles.

Source files
------------

// File: rtl/fpu_serial_io.sv
// fpu_serial_io: handshaked serial front end for the half-precision add/mul
// datapath. Operands arrive LSB-first in IN_W-bit beats, the selected unit
// result is captured after a one-cycle settle, and the result leaves in
// OUT_W-bit beats under ready/valid backpressure.
module fpu_serial_io #(
    parameter int DATA_W = 16,
    parameter int IN_W   = 4,
    parameter int OUT_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_a,
    input  logic [IN_W-1:0]   in_b,
    input  logic              op_sel,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    input  logic [DATA_W-1:0] add_res,
    input  logic              add_vld,
    input  logic [DATA_W-1:0] mul_res,
    input  logic              mul_vld,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              out_flag,
    output logic              busy
);

    localparam int N_IN   = DATA_W / IN_W;
    localparam int N_OUT  = DATA_W / OUT_W;
    // Counters keep at least one bit so single-beat splits still elaborate.
    localparam int IN_CW  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int OUT_CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [IN_CW-1:0]  in_cnt_q,  in_cnt_d;
    logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;
    logic              sel_q,     sel_d;
    logic [DATA_W-1:0] opa_q,     opa_d;
    logic [DATA_W-1:0] opb_q,     opb_d;
    logic [DATA_W-1:0] res_q,     res_d;
    logic              flag_q,    flag_d;

    // Next-state logic: beat collection, result capture and beat emission.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        sel_d     = sel_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        flag_d    = flag_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    // Only the slice addressed by in_cnt changes; the rest
                    // keeps the previous transaction until overwritten.
                    for (int i = 0; i < N_IN; i++) begin
                        opa_d[i*IN_W +: IN_W] = (in_cnt_q == IN_CW'(i)) ? in_a : opa_q[i*IN_W +: IN_W];
                        opb_d[i*IN_W +: IN_W] = (in_cnt_q == IN_CW'(i)) ? in_b : opb_q[i*IN_W +: IN_W];
                    end
                    sel_d = (in_cnt_q == {IN_CW{1'b0}}) ? op_sel : sel_q;
                    if (in_cnt_q == IN_CW'(N_IN - 1)) begin
                        in_cnt_d = {IN_CW{1'b0}};
                        state_d  = ST_CALC;
                    end else begin
                        in_cnt_d = in_cnt_q + IN_CW'(1);
                    end
                end else begin
                    in_cnt_d = in_cnt_q;
                end
            end
            ST_CALC: begin
                // Units have had a full cycle on stable operands.
                res_d     = sel_q ? add_res : mul_res;
                flag_d    = sel_q ? add_vld : mul_vld;
                out_cnt_d = {OUT_CW{1'b0}};
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (out_cnt_q == OUT_CW'(N_OUT - 1)) begin
                        out_cnt_d = {OUT_CW{1'b0}};
                        state_d   = ST_LOAD;
                    end else begin
                        out_cnt_d = out_cnt_q + OUT_CW'(1);
                    end
                end else begin
                    out_cnt_d = out_cnt_q;
                end
            end
            default: begin
                // Unreachable encoding: recover to an idle, empty load.
                state_d   = ST_LOAD;
                in_cnt_d  = {IN_CW{1'b0}};
                out_cnt_d = {OUT_CW{1'b0}};
            end
        endcase
    end

    // State registers with asynchronous clear to the idle LOAD state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_LOAD;
            in_cnt_q  <= {IN_CW{1'b0}};
            out_cnt_q <= {OUT_CW{1'b0}};
            sel_q     <= 1'b0;
            opa_q     <= {DATA_W{1'b0}};
            opb_q     <= {DATA_W{1'b0}};
            res_q     <= {DATA_W{1'b0}};
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            sel_q     <= sel_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res_q     <= res_d;
            flag_q    <= flag_d;
        end
    end

    // Output slice select, driven only from registered state.
    always_comb begin
        out_data = {OUT_W{1'b0}};
        for (int j = 0; j < N_OUT; j++) begin
            out_data = (out_cnt_q == OUT_CW'(j)) ? res_q[j*OUT_W +: OUT_W] : out_data;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_SEND);
    assign out_last  = (state_q == ST_SEND) && (out_cnt_q == OUT_CW'(N_OUT - 1));
    assign out_flag  = flag_q;
    assign opa       = opa_q;
    assign opb       = opb_q;
    assign busy      = (state_q != ST_LOAD) || (in_cnt_q != {IN_CW{1'b0}});

endmodule

// File: tb/tb_fpu_serial_io.sv
// Directed testbench for fpu_serial_io: default 16/4/8 split plus a 32/8/16
// instance with echoing stub units.
module tb_fpu_serial_io;

    logic        clock;
    logic        reset_n;

    // Default-parameter instance
    logic        in_valid, in_ready, op_sel;
    logic [3:0]  in_a, in_b;
    logic [15:0] opa, opb, add_res, mul_res;
    logic        add_vld, mul_vld;
    logic        out_valid, out_ready, out_last, out_flag, busy;
    logic [7:0]  out_data;

    // Wide instance
    logic        in_valid2, in_ready2, op_sel2;
    logic [7:0]  in_a2, in_b2;
    logic [31:0] opa2, opb2, add_res2, mul_res2;
    logic        out_valid2, out_ready2, out_last2, out_flag2, busy2;
    logic [15:0] out_data2;

    int n_checks = 0;
    int n_errors = 0;

    fpu_serial_io dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .op_sel(op_sel),
        .opa(opa), .opb(opb),
        .add_res(add_res), .add_vld(add_vld), .mul_res(mul_res), .mul_vld(mul_vld),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_flag(out_flag), .busy(busy)
    );

    fpu_serial_io #(.DATA_W(32), .IN_W(8), .OUT_W(16)) dut2 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2), .op_sel(op_sel2),
        .opa(opa2), .opb(opb2),
        .add_res(add_res2), .add_vld(1'b1), .mul_res(mul_res2), .mul_vld(1'b0),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_last(out_last2), .out_flag(out_flag2), .busy(busy2)
    );

    // Clock: 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stub units: exact FP16 results for 1.0 and 2.0, simple mixes otherwise.
    always_comb begin
        if (opa == 16'h3C00 && opb == 16'h4000) begin
            add_res = 16'h4200;
            mul_res = 16'h4000;
        end else begin
            add_res = opa + opb;
            mul_res = opa ^ opb;
        end
    end

    // Wide stub units echo opa+opb.
    assign add_res2 = opa2 + opb2;
    assign mul_res2 = opa2 + opb2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction on the default instance, with optional stalls.
    task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic sel, input int in_stall, input int out_stall,
                           input logic [15:0] exp, input logic flg);
        int cyc;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_a     = a[k*4 +: 4];
            in_b     = b[k*4 +: 4];
            op_sel   = (k == 0) ? sel : ~sel;
            check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
            @(posedge clock); #1; cyc++;
            in_valid = 1'b0;
            if (k < 3) begin
                for (int s = 0; s < in_stall; s++) begin
                    check_eq({tag, "_stall_busy"}, {31'd0, busy}, 32'd1);
                    @(posedge clock); #1; cyc++;
                end
            end
        end
        // CALC cycle
        check_eq({tag, "_calc_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_calc_ready"}, {31'd0, in_ready}, 32'd0);
        check_eq({tag, "_opa"}, {16'd0, opa}, {16'd0, a});
        check_eq({tag, "_opb"}, {16'd0, opb}, {16'd0, b});
        @(posedge clock); #1; cyc++;
        for (int j = 0; j < 2; j++) begin
            check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            check_eq({tag, "_data"}, {24'd0, out_data}, {24'd0, exp[j*8 +: 8]});
            check_eq({tag, "_last"}, {31'd0, out_last}, (j == 1) ? 32'd1 : 32'd0);
            check_eq({tag, "_flag"}, {31'd0, out_flag}, {31'd0, flg});
            check_eq({tag, "_send_ready"}, {31'd0, in_ready}, 32'd0);
            if (j == 0) begin
                for (int s = 0; s < out_stall; s++) begin
                    out_ready = 1'b0;
                    @(posedge clock); #1; cyc++;
                    check_eq({tag, "_bp_valid"}, {31'd0, out_valid}, 32'd1);
                    check_eq({tag, "_bp_data"}, {24'd0, out_data}, {24'd0, exp[7:0]});
                    check_eq({tag, "_bp_last"}, {31'd0, out_last}, 32'd0);
                    check_eq({tag, "_bp_ready"}, {31'd0, in_ready}, 32'd0);
                end
            end
            out_ready = 1'b1;
            @(posedge clock); #1; cyc++;
        end
        check_eq({tag, "_end_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_end_ready"}, {31'd0, in_ready}, 32'd1);
        check_eq({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_cycles"}, cyc, 4 + 3 * in_stall + 1 + 2 + out_stall);
    endtask

    initial begin
        logic [31:0] a2;
        logic [31:0] b2;
        int          cyc2;

        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_a      = 4'hF;
        in_b      = 4'hF;
        op_sel    = 1'b1;
        out_ready = 1'b1;
        add_vld   = 1'b1;
        mul_vld   = 1'b0;
        in_valid2 = 1'b0;
        in_a2     = 8'h00;
        in_b2     = 8'h00;
        op_sel2   = 1'b1;
        out_ready2 = 1'b1;

        // Reset state with a beat offered that must be discarded.
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
        check_eq("rst_out_flag", {31'd0, out_flag}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_opa", {16'd0, opa}, 32'd0);
        check_eq("rst_opb", {16'd0, opb}, 32'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clock); #1;
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

        // Add and multiply of 1.0 and 2.0.
        run_txn("add", 16'h3C00, 16'h4000, 1'b1, 0, 0, 16'h4200, 1'b1);
        run_txn("mul", 16'h3C00, 16'h4000, 1'b0, 0, 0, 16'h4000, 1'b0);
        // Multiply path picks mul_vld for the flag.
        add_vld = 1'b0;
        mul_vld = 1'b1;
        run_txn("mulflag", 16'h00A5, 16'h5A00, 1'b0, 0, 0, 16'h5AA5, 1'b1);
        add_vld = 1'b1;
        mul_vld = 1'b0;
        // Output backpressure.
        run_txn("bp", 16'h3C00, 16'h4000, 1'b1, 0, 5, 16'h4200, 1'b1);
        // Input stalls.
        run_txn("stall1", 16'h3C00, 16'h4000, 1'b1, 1, 0, 16'h4200, 1'b1);
        run_txn("stall2", 16'h1234, 16'h0F0F, 1'b1, 2, 0, 16'h2143, 1'b1);

        // Reset after two beats of a load, then a clean transaction.
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_a     = 4'hE;
            in_b     = 4'hD;
            op_sel   = 1'b0;
            @(posedge clock); #1;
        end
        check_eq("midrst_busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_opa", {16'd0, opa}, 32'd0);
        repeat (2) begin
            @(posedge clock); #1;
            check_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clock); #1;
        run_txn("midrst_txn", 16'h1234, 16'h0F0F, 1'b1, 0, 0, 16'h2143, 1'b1);

        // Wide instance: 32-bit data, 8-bit input beats, 16-bit output beats.
        a2   = 32'h11223344;
        b2   = 32'h01020304;
        cyc2 = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid2 = 1'b1;
            in_a2     = a2[k*8 +: 8];
            in_b2     = b2[k*8 +: 8];
            @(posedge clock); #1; cyc2++;
        end
        in_valid2 = 1'b0;
        check_eq("w_calc_valid", {31'd0, out_valid2}, 32'd0);
        check_eq("w_opa", opa2, 32'h11223344);
        @(posedge clock); #1; cyc2++;
        check_eq("w_valid0", {31'd0, out_valid2}, 32'd1);
        check_eq("w_data0", {16'd0, out_data2}, 32'h00003648);
        check_eq("w_last0", {31'd0, out_last2}, 32'd0);
        check_eq("w_flag", {31'd0, out_flag2}, 32'd1);
        @(posedge clock); #1; cyc2++;
        check_eq("w_data1", {16'd0, out_data2}, 32'h00001224);
        check_eq("w_last1", {31'd0, out_last2}, 32'd1);
        @(posedge clock); #1; cyc2++;
        check_eq("w_end_valid", {31'd0, out_valid2}, 32'd0);
        check_eq("w_end_ready", {31'd0, in_ready2}, 32'd1);
        check_eq("w_cycles", cyc2, 32'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
